// File: rtl/ysyx_23060332_pc_gen.sv
// ysyx_23060332_pc_gen
// Instruction-fetch PC generator. It issues one fetch request at a time to
// instruction memory, holds the returned instruction for decode, and then
// advances the PC sequentially. A trap or jump redirect reloads the PC from an
// aligned target. A response that belongs to a redirected request is
// discarded rather than delivered.
module ysyx_23060332_pc_gen #(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(32'h8000_0000),
    parameter int unsigned       STEP      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              trap_en,
    input  logic [ADDR_W-1:0] trap_addr,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_addr,
    output logic              req_valid,
    output logic [ADDR_W-1:0] req_addr,
    input  logic              req_ready,
    input  logic              rsp_valid,
    input  logic [31:0]       rsp_data,
    output logic              out_valid,
    output logic [ADDR_W-1:0] out_pc,
    output logic [31:0]       out_inst,
    input  logic              out_ready
);

    // IDLE : one settling cycle after reset; redirects are ignored here
    // REQ  : request presented to memory
    // WAIT : request accepted, waiting for the response
    // HOLD : instruction presented to decode
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [ADDR_W-1:0] STEP_W     = ADDR_W'(STEP);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(STEP_W - ADDR_W'(1));

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_pc;
    logic [ADDR_W-1:0] w_fetch_pc_nxt;
    logic              r_drop;
    logic              w_drop_nxt;
    logic [31:0]       r_inst_q;
    logic [31:0]       w_inst_q_nxt;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_target;

    // Redirect request and aligned target; a trap wins over a jump
    always_comb begin
        w_redirect = trap_en | jump_en;
        w_target   = (trap_en ? trap_addr : jump_addr) & ALIGN_MASK;
    end

    // Next-state, PC, drop flag and instruction-latch update
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_drop_nxt     = r_drop;
        w_inst_q_nxt   = r_inst_q;

        unique case (r_state)
            IDLE: begin
                w_state_nxt = REQ;
            end

            REQ: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                    if (req_ready) begin
                        // The accepted request still points at the old PC.
                        // Its response must be thrown away.
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = WAIT;
                    end
                end else if (req_ready) begin
                    w_state_nxt = WAIT;
                end
            end

            WAIT: begin
                if (w_redirect) begin
                    w_fetch_pc_nxt = w_target;
                    if (rsp_valid) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_drop_nxt = 1'b1;
                    end
                end else if (rsp_valid) begin
                    if (r_drop) begin
                        w_drop_nxt  = 1'b0;
                        w_state_nxt = REQ;
                    end else begin
                        w_inst_q_nxt = rsp_data;
                        w_state_nxt  = HOLD;
                    end
                end
            end

            HOLD: begin
                if (w_redirect) begin
                    // Any handshake this cycle still delivers the instruction.
                    // The redirect target replaces the sequential increment.
                    w_fetch_pc_nxt = w_target;
                    w_state_nxt    = REQ;
                end else if (out_ready) begin
                    w_fetch_pc_nxt = r_fetch_pc + STEP_W;
                    w_state_nxt    = REQ;
                end
            end

            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_VEC;
            r_drop     <= 1'b0;
            r_inst_q   <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_fetch_pc <= w_fetch_pc_nxt;
            r_drop     <= w_drop_nxt;
            r_inst_q   <= w_inst_q_nxt;
        end
    end

    // Outputs decode directly from registered state, so reset clears them without an edge
    always_comb begin
        req_valid = (r_state == REQ);
        req_addr  = r_fetch_pc;
        out_valid = (r_state == HOLD);
        out_pc    = r_fetch_pc;
        out_inst  = r_inst_q;
    end

endmodule

// File: tb/tb_ysyx_23060332_pc_gen.sv
// Testbench for ysyx_23060332_pc_gen.
// A transaction-level model tracks the expected fetch PC, the single
// outstanding request and its staleness, and any instruction awaiting decode.
// A behavioural memory answers requests with an address-derived instruction.
module tb_ysyx_23060332_pc_gen;

    localparam logic [31:0] RV   = 32'h8000_0000;
    localparam int unsigned STEP = 4;

    logic        clk;
    logic        rst;
    logic        trap_en;
    logic [31:0] trap_addr;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        req_valid;
    logic [31:0] req_addr;
    logic        req_ready;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_ready;

    // Second instance exercising PC wrap from the top of the address space
    logic        rst2;
    logic        req_valid2;
    logic [31:0] req_addr2;
    logic        rsp_valid2;
    logic        out_valid2;
    logic [31:0] out_pc2;
    logic [31:0] out_inst2;

    int n_checks;
    int n_errors;

    // Reference model state
    logic        m_idle;
    logic [31:0] m_pc;
    logic        m_out;
    logic        m_stale;
    logic        m_hold;

    // Memory model state
    logic        mem_busy;
    int          mem_cnt;
    logic [31:0] mem_addr;
    int          mem_lo;
    int          mem_hi;
    logic        mem_stray;

    ysyx_23060332_pc_gen #(
        .ADDR_W   (32),
        .RESET_VEC(RV),
        .STEP     (STEP)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .trap_en  (trap_en),
        .trap_addr(trap_addr),
        .jump_en  (jump_en),
        .jump_addr(jump_addr),
        .req_valid(req_valid),
        .req_addr (req_addr),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .out_valid(out_valid),
        .out_pc   (out_pc),
        .out_inst (out_inst),
        .out_ready(out_ready)
    );

    ysyx_23060332_pc_gen #(
        .RESET_VEC(32'hFFFF_FFFC)
    ) u_wrap (
        .clk      (clk),
        .rst      (rst2),
        .trap_en  (1'b0),
        .trap_addr(32'h0),
        .jump_en  (1'b0),
        .jump_addr(32'h0),
        .req_valid(req_valid2),
        .req_addr (req_addr2),
        .req_ready(1'b1),
        .rsp_valid(rsp_valid2),
        .rsp_data (32'h0000_0013),
        .out_valid(out_valid2),
        .out_pc   (out_pc2),
        .out_inst (out_inst2),
        .out_ready(1'b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction word the memory stores at a given address
    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return ((a - RV) * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rand_addr();
        if ($urandom_range(3, 0) == 0) return 32'hFFFF_FFF0 | ($urandom & 32'hF);
        return RV | ($urandom & 32'hFFFF);
    endfunction

    // Assert reset (whatever the clock phase), check the reset outputs, release on a falling edge
    task automatic do_reset();
        rst       = 1'b0;
        trap_en   = 1'b0;
        jump_en   = 1'b0;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        check("rst_req_valid", req_valid, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_req_addr", req_addr, RV);
        check("rst_out_pc", out_pc, RV);
        check("rst_out_inst", out_inst, 32'h0);
        m_idle    = 1'b1;
        m_pc      = RV;
        m_out     = 1'b0;
        m_stale   = 1'b0;
        m_hold    = 1'b0;
        mem_busy  = 1'b0;
        mem_cnt   = 0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // One clock cycle, entered and left on a falling edge
    task automatic tick(input logic t_en, input logic [31:0] t_a, input logic j_en,
                        input logic [31:0] j_a, input logic o_rdy, input logic r_rdy);
        logic        redir;
        logic [31:0] tgt;
        logic        rsp;

        check("req_valid", req_valid, !m_idle && !m_out && !m_hold);
        check("req_addr", req_addr, m_pc);
        check("out_valid", out_valid, m_hold);
        if (m_hold) begin
            check("out_pc", out_pc, m_pc);
            check("out_inst", out_inst, inst_of(m_pc));
        end

        rsp = mem_stray || (mem_busy && mem_cnt == 0);
        rsp_data = rsp ? inst_of(mem_stray ? 32'h8000_0000 + 32'h40 : mem_addr) : $urandom;
        if (mem_busy) begin
            if (mem_cnt == 0) mem_busy = 1'b0;
            else mem_cnt--;
        end
        if (req_valid && r_rdy) begin
            mem_busy = 1'b1;
            mem_addr = req_addr;
            mem_cnt  = $urandom_range(mem_hi, mem_lo);
        end

        trap_en   = t_en;
        trap_addr = t_a;
        jump_en   = j_en;
        jump_addr = j_a;
        out_ready = o_rdy;
        req_ready = r_rdy;
        rsp_valid = rsp;

        redir = !m_idle && (t_en || j_en);
        tgt   = (t_en ? t_a : j_a) & ~(STEP - 1);
        if (m_idle) begin
            m_idle = 1'b0;
        end else if (m_hold) begin
            if (o_rdy || redir) m_hold = 1'b0;
            if (o_rdy && !redir) m_pc = m_pc + STEP;
        end else if (m_out) begin
            if (rsp) begin
                m_out = 1'b0;
                if (!m_stale && !redir) m_hold = 1'b1;
                m_stale = 1'b0;
            end else if (redir) begin
                m_stale = 1'b1;
            end
        end else if (r_rdy) begin
            m_out   = 1'b1;
            m_stale = redir;
        end
        if (redir) m_pc = tgt;

        @(negedge clk);
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_inst;
        int k;

        n_checks  = 0;
        n_errors  = 0;
        mem_stray = 1'b0;
        mem_lo    = 0;
        mem_hi    = 0;
        trap_addr = '0;
        jump_addr = '0;
        rsp_data  = '0;
        rst       = 1'b1;
        rst2      = 1'b1;
        rsp_valid2 = 1'b0;
        @(negedge clk);
        do_reset();

        // Redirect in IDLE is ignored; then a basic in-order fetch
        tick(1'b0, 32'h0, 1'b1, 32'h1234_5678, 1'b1, 1'b1);
        k = 0;
        while (!out_valid && k < 20) begin
            tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1);
            k++;
        end
        check("first_out_valid", out_valid, 1'b1);
        check("first_out_pc", out_pc, 32'h8000_0000);
        check("first_out_inst", out_inst, 32'h0000_0013);
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
        check("next_req_valid", req_valid, 1'b1);
        check("next_req_addr", req_addr, 32'h8000_0004);

        // Decode stall: HOLD outputs stay put
        k = 0;
        while (!out_valid && k < 20) begin
            tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end
        check("stall_enter", out_valid, 1'b1);
        held_pc   = out_pc;
        held_inst = out_inst;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_out_pc", out_pc, held_pc);
            check("stall_out_inst", out_inst, held_inst);
            check("stall_req_valid", req_valid, 1'b0);
        end
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);

        // Jump during WAIT; the late response must be dropped
        mem_lo = 1;
        mem_hi = 1;
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b1, 32'h8000_1002, 1'b1, 1'b0);
        k = 0;
        while (!req_valid && k < 8) begin
            check("drop_out_valid", out_valid, 1'b0);
            tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
            k++;
        end
        check("drop_out_valid_end", out_valid, 1'b0);
        check("drop_req_valid", req_valid, 1'b1);
        check("drop_req_addr", req_addr, 32'h8000_1000);

        // Trap beats jump in REQ
        tick(1'b1, 32'h8000_2000, 1'b1, 32'h8000_3000, 1'b0, 1'b0);
        check("prio_req_valid", req_valid, 1'b1);
        check("prio_req_addr", req_addr, 32'h8000_2000);

        // Reset mid-WAIT; stray responses in IDLE/REQ afterwards are ignored
        mem_lo = 2;
        mem_hi = 2;
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        do_reset();
        mem_stray = 1'b1;
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        mem_stray = 1'b0;
        mem_lo = 0;
        mem_hi = 0;
        k = 0;
        while (!out_valid && k < 20) begin
            tick(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            k++;
        end
        check("post_rst_out_valid", out_valid, 1'b1);
        check("post_rst_out_pc", out_pc, 32'h8000_0000);
        check("post_rst_out_inst", out_inst, 32'h0000_0013);

        // Asynchronous reset while in HOLD, away from any clock edge
        #2;
        do_reset();

        // Randomized traffic against the model
        mem_lo = 0;
        mem_hi = 3;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(999, 0) == 0) begin
                do_reset();
            end else begin
                tick($urandom_range(99, 0) < 4, rand_addr(),
                     $urandom_range(99, 0) < 8, rand_addr(),
                     $urandom_range(99, 0) < 70, $urandom_range(99, 0) < 70);
            end
        end

        // PC wrap with RESET_VEC at the top of the address space
        rst2 = 1'b0;
        @(negedge clk);
        rst2 = 1'b1;
        k = 0;
        begin
            logic pend2;
            pend2 = 1'b0;
            while (!out_valid2 && k < 20) begin
                rsp_valid2 = pend2;
                pend2      = req_valid2;
                @(negedge clk);
                k++;
            end
        end
        rsp_valid2 = 1'b0;
        check("wrap_out_valid", out_valid2, 1'b1);
        check("wrap_out_pc", out_pc2, 32'hFFFF_FFFC);
        check("wrap_out_inst", out_inst2, 32'h0000_0013);
        @(negedge clk);
        check("wrap_req_valid", req_valid2, 1'b1);
        check("wrap_req_addr", req_addr2, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ysyx_23060332_pc_gen.md
YSYX_23060332_PC_GEN -- requirements
Module: ysyx_23060332_pc_gen

Interface
REQ-001 SHALL provide parameter ADDR_W, default 32, meaning address/PC width in bits.
REQ-002 SHALL provide parameter RESET_VEC, default 32'h80000000, meaning first fetch address after reset.
REQ-003 SHALL provide parameter STEP, default 4, meaning sequential PC increment in bytes (power of two).
REQ-004 SHALL have ports:
 clk  in  1  clock, all state updates on rising edge
 rst  in  1  asynchronous reset, active-low
 trap_en  in  1  trap redirect request
 trap_addr  in  ADDR_W  trap target
 jump_en  in  1  branch/jump redirect from exu
 jump_addr  in  ADDR_W  jump target
 req_valid  out  1  fetch request to instruction memory
 req_addr  out  ADDR_W  fetch address
 req_ready  in  1  memory accepts request
 rsp_valid  in  1  memory returns instruction
 rsp_data  in  32  returned instruction
 out_valid  out  1  instruction valid to decode
 out_pc  out  ADDR_W  PC of out_inst
 out_inst  out  32  instruction to decode
 out_ready  in  1  decode accepts instruction

Function
REQ-005 SHALL implement FSM with states IDLE, REQ, WAIT, HOLD plus registers fetch_pc (ADDR_W), drop (1), inst_q (32).
REQ-006 SHALL drive req_valid=1 only in REQ, req_addr=fetch_pc always.
REQ-007 SHALL drive out_valid=1 only in HOLD, out_pc=fetch_pc, out_inst=inst_q.
REQ-008 IDLE SHALL move to REQ unconditionally on the next edge.
REQ-009 REQ SHALL move to WAIT when req_ready=1, else remain in REQ.
REQ-010 WAIT SHALL, on rsp_valid=1 with drop=0, capture rsp_data into inst_q and move to HOLD.
REQ-011 WAIT SHALL, on rsp_valid=1 with drop=1, discard rsp_data, clear drop, move to REQ.
REQ-012 HOLD SHALL, on out_ready=1, set fetch_pc=fetch_pc+STEP and move to REQ; else hold out_* stable.
REQ-013 At most one request SHALL be outstanding; no req_valid while in WAIT or HOLD.
REQ-014 Redirect (trap_en or jump_en) SHALL take effect in any non-IDLE state; trap_en has priority over jump_en.
REQ-015 Redirect target SHALL have its low log2(STEP) bits forced to zero before loading fetch_pc.
REQ-016 Redirect in REQ with req_ready=0: fetch_pc=target, stay REQ (req_addr changes next cycle).
REQ-017 Redirect in REQ with req_ready=1: fetch_pc=target, drop=1, move to WAIT (accepted request is stale).
REQ-018 Redirect in WAIT (with or without rsp_valid): fetch_pc=target; if rsp_valid=1 discard it, clear drop, move to REQ; else set drop=1, stay WAIT.
REQ-019 Redirect in HOLD: instruction delivered iff out_ready=1 same cycle; in all cases fetch_pc=target, move to REQ, out_valid=0 next cycle.
REQ-020 Redirect SHALL override the +STEP update of REQ-012.
REQ-021 fetch_pc+STEP SHALL wrap modulo 2^ADDR_W with no error indication.
REQ-022 Redirect in IDLE SHALL be ignored.

Reset
REQ-023 rst=0 SHALL asynchronously force state=IDLE, fetch_pc=RESET_VEC, drop=0, inst_q=0; hence req_valid=0, out_valid=0, req_addr=out_pc=RESET_VEC, out_inst=0.
REQ-024 Reset asserted mid-transaction SHALL abandon any outstanding request; the response, if it arrives after release, SHALL be ignored only if it arrives while in IDLE or REQ (memory is reset with this block).

Verification
REQ-025 Release reset, req_ready=1, rsp_valid one cycle after accept with 32'h00000013, out_ready=1 -> req_addr 0x80000000, out_pc 0x80000000 out_inst 0x00000013, next req_addr 0x80000004.
REQ-026 Hold out_ready=0 for 5 cycles in HOLD -> out_valid, out_pc, out_inst stable, no req_valid.
REQ-027 jump_en=1 jump_addr=0x80001002 during WAIT, response arrives next cycle -> response discarded, out_valid stays 0, next req_addr 0x80001000.
REQ-028 trap_en=1 trap_addr=0x80002000 and jump_en=1 jump_addr=0x80003000 same cycle in REQ -> next req_addr 0x80002000.
REQ-029 RESET_VEC=32'hFFFFFFFC, deliver one instruction -> next req_addr 0x00000000.
REQ-030 Assert rst=0 asynchronously while in HOLD -> out_valid and req_valid fall immediately, req_addr=RESET_VEC without a clock edge.
